mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be declared one per line as name, default, meaning:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 4, memory address width (DEPTH 16)
- DATA_W, 8, memory data width (WIDTH 8)
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester request
- req_we  input  NUM_REQ  per-requester write enable (1 = write)
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  input  NUM_REQ*DATA_W  packed write data
- req_ready  output  NUM_REQ  one-hot accept
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumer ready
- rsp_id  output  clog2(NUM_REQ)  index of the responding requester
- rsp_we  output  1  response is a write acknowledge
- rsp_rdata  output  DATA_W  read data (zero for writes)
- mem_en, mem_we  output  1 each  memory strobe and write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_en
- busy  output  1  high whenever the FSM is not in IDLE
- txn_cnt  output  16  count of completed responses

Function
REQ-003 The block SHALL have exactly one transaction outstanding, sequenced by FSM states IDLE, ISSUE, CAPTURE and RESP.
REQ-004 In IDLE with any req_valid bit set, req_ready SHALL assert combinationally for exactly one winner g, for one cycle.
REQ-005 On that cycle the block SHALL latch g, req_we[g], the address of g and the write data of g, and go to ISSUE.
REQ-006 In IDLE with no req_valid bit set, req_ready SHALL be all zero and the FSM SHALL stay in IDLE.
REQ-007 The winner SHALL be the first set req_valid bit searching upward, wrapping, from (last_grant+1) mod NUM_REQ.
REQ-008 last_grant SHALL update to g on acceptance.
REQ-009 ISSUE SHALL last one cycle, with mem_en=1 and mem_we, mem_addr, mem_wdata driven from registers; then the FSM SHALL go to CAPTURE.
REQ-010 Outside ISSUE, mem_en and mem_we SHALL be 0; mem_addr and mem_wdata SHALL hold their last values.
REQ-011 CAPTURE SHALL last one cycle and register mem_rdata into rsp_rdata for a read, or zero for a write; then the FSM SHALL go to RESP.
REQ-012 In RESP, rsp_valid SHALL be 1, and rsp_id, rsp_we and rsp_rdata SHALL stay stable until the cycle rsp_valid and rsp_ready are both 1.
REQ-013 On that handshake the FSM SHALL return to IDLE and txn_cnt SHALL increment by 1, wrapping from 0xFFFF to 0.
REQ-014 The minimum acceptance-to-rsp_valid latency SHALL be 3 cycles, and the minimum spacing between accepts SHALL be 4 cycles.
REQ-015 Changes to req_valid, req_addr or req_wdata after acceptance SHALL NOT affect the transaction in flight.
REQ-016 A requester dropping req_valid while not granted SHALL simply lose arbitration; no request SHALL be queued.
REQ-017 If rsp_ready is already 1 when RESP is entered, the response SHALL complete in that same cycle.

Reset
REQ-018 On rst_n=0, asynchronously: FSM=IDLE, last_grant=NUM_REQ-1, and all outputs 0, including rsp_valid, mem_en, txn_cnt and busy.
REQ-019 Reset asserted mid-transaction SHALL abandon it with no response and no memory write after reset.
REQ-020 Release of rst_n SHALL take effect on the next clk edge, and requester 0 SHALL have first priority.

Verification
REQ-021 Single read: req_valid=0001, addr0=3, memory[3]=0xA5, rsp_ready=1 -> req_ready=0001 at cycle 0; mem_en at cycle 1; rsp_valid, rsp_id=0, rsp_rdata=0xA5 at cycle 3; txn_cnt=1.
REQ-022 Write then read: requester 2 writes 0x3C to address 7, then requester 1 reads address 7 -> write response has rsp_we=1 and rdata=0; read returns 0x3C.
REQ-023 Round robin: req_valid=1111 held, rsp_ready=1 -> grant order 0,1,2,3,0 with accepts every 4 cycles.
REQ-024 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_rdata stable; req_ready=0 and mem_en=0 throughout; completes on the cycle rsp_ready rises.
REQ-025 Reset mid-op: rst_n low during CAPTURE -> rsp_valid never asserts; after release, req_valid=1010 grants requester 1 first.
REQ-026 Counter wrap: txn_cnt forced by stimulus to 0xFFFF, then one completed response -> txn_cnt=0x0000.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that gives several requesters access to one single-port
// synchronous memory, with exactly one transaction in flight at a time.
module mem_port_arbiter #(
    parameter int NUM_REQ = 4, // number of requesters (2..8)
    parameter int ADDR_W  = 4, // memory address width
    parameter int DATA_W  = 8  // memory data width
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic                        rsp_we,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        busy,
    output logic [15:0]                 txn_cnt
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [15:0]         txn_cnt_q, txn_cnt_d;

    logic                grant_found;
    logic [ID_W-1:0]     grant_idx;
    logic [NUM_REQ-1:0]  grant_onehot;
    int                  cand;

    // Search upward from the requester after the last winner, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant_q) + k) % NUM_REQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        txn_cnt_d    = txn_cnt_q;
        grant_onehot = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    grant_onehot[grant_idx] = 1'b1;
                    last_grant_d = grant_idx;
                    id_d         = grant_idx;
                    we_d         = req_we[grant_idx];
                    addr_d       = req_addr[grant_idx*ADDR_W +: ADDR_W];
                    wdata_d      = req_wdata[grant_idx*DATA_W +: DATA_W];
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                rdata_d = we_q ? '0 : mem_rdata;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    txn_cnt_d = txn_cnt_q + 16'd1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            txn_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            txn_cnt_q    <= txn_cnt_d;
        end
    end

    // Grants are masked while reset is held so every output reads zero then.
    assign req_ready = rst_n ? grant_onehot : '0;
    assign busy      = (state_q != ST_IDLE);
    assign mem_en    = (state_q == ST_ISSUE);
    assign mem_we    = (state_q == ST_ISSUE) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = id_q;
    assign rsp_we    = we_q;
    assign rsp_rdata = rdata_q;
    assign txn_cnt   = txn_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run, all
// cycles compared against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 8;

    localparam logic [DW-1:0] MEM_INIT [16] = '{
        8'h11, 8'h22, 8'h33, 8'hA5, 8'h44, 8'h5A, 8'h66, 8'h77,
        8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hF0
    };

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic            rsp_we;
    logic [DW-1:0]   rsp_rdata;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata = '0;
    logic            busy;
    logic [15:0]     txn_cnt;

    mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_we(rsp_we),
        .rsp_rdata(rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy(busy), .txn_cnt(txn_cnt)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Synchronous memory attached to the memory port
    logic [DW-1:0] mem_arr [16] = MEM_INIT;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            mem_rdata <= mem_arr[mem_addr];
        end
    end

    // Scoreboard counters and reference model state
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] ref_mem [16] = MEM_INIT;
    bit            m_active = 1'b0;
    int            m_age = 0;
    int            m_last = N - 1;
    int            m_id = 0;
    bit            m_we = 1'b0;
    logic [AW-1:0] m_maddr = '0;
    logic [DW-1:0] m_mwdata = '0;
    logic [DW-1:0] m_rdata = '0;
    logic [15:0]   m_cnt = '0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Compares every output against the model for the current cycle, then
    // advances the model by the rules: one txn in flight, memory access one
    // cycle after accept, response from the third cycle after accept.
    task automatic model_step();
        logic [N-1:0] exp_ready;
        int g;
        int c;
        if (!rst_n) begin
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_mem_en", 32'(mem_en), 0);
            chk("rst_mem_we", 32'(mem_we), 0);
            chk("rst_mem_addr", 32'(mem_addr), 0);
            chk("rst_mem_wdata", 32'(mem_wdata), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_rsp_id", 32'(rsp_id), 0);
            chk("rst_rsp_we", 32'(rsp_we), 0);
            chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
            chk("rst_txn_cnt", 32'(txn_cnt), 0);
            m_active = 1'b0;
            m_last   = N - 1;
            m_cnt    = '0;
            m_maddr  = '0;
            m_mwdata = '0;
            return;
        end
        exp_ready = '0;
        g = -1;
        if (!m_active) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (g < 0 && req_valid[c]) g = c;
            end
            if (g >= 0) exp_ready[g] = 1'b1;
        end
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("busy", 32'(busy), 32'(m_active));
        chk("mem_en", 32'(mem_en), 32'(m_active && m_age == 1));
        chk("mem_we", 32'(mem_we), 32'(m_active && m_age == 1 && m_we));
        chk("mem_addr", 32'(mem_addr), 32'(m_maddr));
        chk("mem_wdata", 32'(mem_wdata), 32'(m_mwdata));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_active && m_age >= 3));
        if (m_active && m_age >= 3) begin
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("rsp_we", 32'(rsp_we), 32'(m_we));
            chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
        end
        chk("txn_cnt", 32'(txn_cnt), 32'(m_cnt));

        if (!m_active) begin
            if (g >= 0) begin
                m_active = 1'b1;
                m_age    = 1;
                m_last   = g;
                m_id     = g;
                m_we     = req_we[g];
                m_maddr  = req_addr[g*AW +: AW];
                m_mwdata = req_wdata[g*DW +: DW];
                m_rdata  = m_we ? '0 : ref_mem[m_maddr];
            end
        end else if (m_age == 1) begin
            if (m_we) ref_mem[m_maddr] = m_mwdata;
            m_age = 2;
        end else if (m_age == 2) begin
            m_age = 3;
        end else if (rsp_ready) begin
            m_active = 1'b0;
            m_cnt    = m_cnt + 16'd1;
        end
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge,
    // outputs are sampled at the falling edge.
    task automatic posc();
        @(posedge clk);
        #1;
    endtask

    task automatic negc();
        @(negedge clk);
        model_step();
    endtask

    task automatic set_req(int i, bit v, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
        req_valid[i] = v;
        req_we[i]    = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    int gr_cyc[$];
    int gr_id[$];
    int w;

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        negc();
        chk("reset_busy", 32'(busy), 0);
        posc();
        negc();

        // Single read of address 3
        posc();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 1'b0, 4'd3, 8'h00);
        negc();
        chk("t1_req_ready", 32'(req_ready), 32'h1);
        posc();
        req_valid = '0;
        negc();
        chk("t1_mem_en", 32'(mem_en), 1);
        chk("t1_mem_addr", 32'(mem_addr), 3);
        posc(); negc();
        posc(); negc();
        chk("t1_rsp_valid", 32'(rsp_valid), 1);
        chk("t1_rsp_id", 32'(rsp_id), 0);
        chk("t1_rsp_rdata", 32'(rsp_rdata), 32'hA5);
        posc(); negc();
        chk("t1_txn_cnt", 32'(txn_cnt), 1);

        // Requester 2 writes 0x3C to address 7, requester 1 reads it back
        posc();
        set_req(2, 1'b1, 1'b1, 4'd7, 8'h3C);
        negc();
        chk("t2_w_ready", 32'(req_ready), 32'h4);
        posc();
        req_valid = '0;
        req_we    = '0;
        negc();
        chk("t2_mem_we", 32'(mem_we), 1);
        posc(); negc();
        posc(); negc();
        chk("t2_w_rsp_id", 32'(rsp_id), 2);
        chk("t2_w_rsp_we", 32'(rsp_we), 1);
        chk("t2_w_rdata", 32'(rsp_rdata), 0);
        posc();
        set_req(1, 1'b1, 1'b0, 4'd7, 8'h00);
        negc();
        chk("t2_r_ready", 32'(req_ready), 32'h2);
        posc();
        req_valid = '0;
        negc();
        posc(); negc();
        posc(); negc();
        chk("t2_r_rsp_id", 32'(rsp_id), 1);
        chk("t2_r_rsp_we", 32'(rsp_we), 0);
        chk("t2_r_rdata", 32'(rsp_rdata), 32'h3C);
        posc(); negc();

        // Round robin from reset with all requesters held
        posc();
        rst_n = 1'b0;
        negc();
        posc();
        rst_n = 1'b1;
        req_valid = 4'b1111;
        req_we    = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            negc();
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    gr_cyc.push_back(cyc);
                    gr_id.push_back(i);
                end
            end
            posc();
        end
        req_valid = '0;
        negc();
        chk("rr_grant_count", 32'(gr_id.size()), 5);
        for (int i = 0; i < 5 && i < gr_id.size(); i++) begin
            chk("rr_grant_id", 32'(gr_id[i]), 32'(i % N));
            chk("rr_grant_cycle", 32'(gr_cyc[i]), 32'(4 * i));
        end

        // Backpressure: requester 1 reads address 5 while rsp_ready is low
        posc();
        req_valid = 4'b1111;
        set_req(1, 1'b1, 1'b0, 4'd5, 8'h00);
        rsp_ready = 1'b0;
        negc();
        chk("bp_ready", 32'(req_ready), 32'h2);
        w = 0;
        while (!rsp_valid && w < 8) begin
            posc();
            negc();
            w++;
        end
        chk("bp_latency", 32'(w), 3);
        for (int i = 0; i < 4; i++) begin
            posc();
            negc();
            chk("bp_rsp_valid", 32'(rsp_valid), 1);
            chk("bp_rsp_id", 32'(rsp_id), 1);
            chk("bp_rsp_rdata", 32'(rsp_rdata), 32'h5A);
            chk("bp_req_ready", 32'(req_ready), 0);
            chk("bp_mem_en", 32'(mem_en), 0);
        end
        posc();
        rsp_ready = 1'b1;
        req_valid = '0;
        negc();
        chk("bp_done_valid", 32'(rsp_valid), 1);
        posc(); negc();
        chk("bp_done_busy", 32'(busy), 0);
        chk("bp_done_cnt", 32'(txn_cnt), 6);

        // Reset asserted during CAPTURE abandons the read
        posc();
        set_req(0, 1'b1, 1'b0, 4'd2, 8'h00);
        negc();
        chk("rm_ready", 32'(req_ready), 32'h1);
        posc();
        req_valid = '0;
        negc();
        posc();
        rst_n = 1'b0;
        #1;
        chk("rm_async_busy", 32'(busy), 0);
        chk("rm_async_valid", 32'(rsp_valid), 0);
        chk("rm_async_cnt", 32'(txn_cnt), 0);
        negc();
        posc(); negc();
        posc();
        rst_n = 1'b1;
        req_valid = 4'b1010;
        negc();
        chk("rm_first_grant", 32'(req_ready), 32'h2);
        posc();
        req_valid = '0;
        negc();
        posc(); negc();
        posc(); negc();
        chk("rm_rsp_id", 32'(rsp_id), 1);
        posc(); negc();

        // Counter wrap from 0xFFFF
        posc();
        force dut.txn_cnt_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        negc();
        posc();
        release dut.txn_cnt_q;
        set_req(2, 1'b1, 1'b0, 4'd0, 8'h00);
        negc();
        chk("wrap_before", 32'(txn_cnt), 32'hFFFF);
        posc();
        req_valid = '0;
        negc();
        posc(); negc();
        posc(); negc();
        posc(); negc();
        chk("wrap_after", 32'(txn_cnt), 0);

        // Randomized traffic with backpressure and occasional resets
        for (int cyc = 0; cyc < 3000; cyc++) begin
            posc();
            rst_n     = ($urandom_range(0, 399) != 0);
            req_valid = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 15)) : N'(1 << $urandom_range(0, N - 1));
            if ($urandom_range(0, 3) == 0) req_valid = '0;
            req_we    = N'($urandom_range(0, 15));
            req_addr  = (N*AW)'($urandom);
            req_wdata = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            negc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
